alu_issue_decode: RTL and testbench
===================================

# alu_issue_decode

Issue-side counterpart of the `alu` block. It decodes RV32I integer-computational instructions (OP, OP-IMM, LUI, AUIPC) into the ALU's `alu_op_t` encoding and selects operands, with forwarding from the EX and WB stages. Results are registered into an ID/EX pipeline stage with a valid/ready handshake and flush. It sits between instruction fetch/register-file read and the EX stage that feeds `alu`.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 supported.

Ports (clock and reset first):
- `clk_i`  in  1  clock. One clock domain only.
- `rst_i`  in  1  reset; synchronous and active-high.
- `valid_i`  in  1  instruction bundle valid.
- `ready_o`  out  1  stage can accept a bundle this cycle.
- `instr_i`  in  32  raw instruction.
- `pc_i`  in  32  instruction PC.
- `rs1_data_i` / `rs2_data_i`  in  32 each  register-file read data.
- `fwd_ex_valid_i`, `fwd_ex_rd_i`, `fwd_ex_data_i`  in  1/5/32  EX-stage writeback candidate.
- `fwd_wb_valid_i`, `fwd_wb_rd_i`, `fwd_wb_data_i`  in  1/5/32  WB-stage writeback candidate.
- `flush_i`  in  1  kill the registered and incoming bundle.
- `valid_o`  out  1  ID/EX bundle valid.
- `ready_i`  in  1  EX accepts the bundle.
- `alu_op_o`  out  `alu_op_t`  operation for `alu`.
- `operand_a_o` / `operand_b_o`  out  32 each  ALU operands.
- `rd_o`  out  5  destination register.
- `rd_we_o`  out  1  write enable; 0 when rd = x0 or the instruction is illegal.
- `illegal_o`  out  1  instruction not decodable by this block.
- `pc_o`  out  32  registered PC.

## Operation
- **Handshake:** `ready_o = !valid_o || ready_i`. A transfer in occurs when `valid_i && ready_o`; a transfer out occurs when `valid_o && ready_i`.
- **Stall:** while `valid_o && !ready_i`, all outputs hold stable.
- **Load:** on a transfer in without flush, the decoded bundle is registered and `valid_o` is set to 1. If no transfer in occurs and the output transfers, `valid_o` goes to 0.
- **Flush:** `flush_i` has priority over everything except reset. Next cycle `valid_o` = 0, and any bundle arriving in the same cycle is dropped.
- **Operand resolution (rs1, rs2 independently):**
  - index 0 yields 0;
  - otherwise, a matching EX candidate (`fwd_ex_valid_i` and rd equal) wins;
  - otherwise, a matching WB candidate;
  - otherwise, register-file data.
- **OP (0110011):**
  - funct7 = 0000000 maps funct3 000..111 to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 = 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - A = rs1, B = rs2.
- **OP-IMM (0010011):**
  - Same funct3 map, with no SUB.
  - B = sign-extended I-immediate `instr[31:20]`.
  - SLLI requires funct7 = 0000000. SRLI/SRAI require funct7 0000000/0100000.
  - B[4:0] = shamt.
- **LUI (0110111):** ADD, A = 0, B = `{instr[31:12], 12'b0}`.
- **AUIPC (0010111):** ADD, A = `pc_i`, B = U-immediate.
- **Anything else, or an illegal funct7:** `illegal_o` = 1, ADD, operands 0, `rd_we_o` = 0. The bundle is still passed with `valid_o` = 1.
- **`rd_o`:** `instr[11:7]`. `rd_we_o` = legal && rd ≠ 0.

## Timing
- Latency is 1 cycle from transfer in to `valid_o`. Throughput is 1 bundle/cycle when `ready_i` is held at 1.
- Forwarding sources are sampled in the transfer-in cycle only. Values are not re-resolved during a stall; upstream must hold rs data that is correct for that cycle.
- **Reset:** `valid_o` = 0, `alu_op_o` = ALU_ADD, all operands, `rd_o`, `rd_we_o`, `illegal_o` and `pc_o` = 0, and `ready_o` = 1 in the following cycle.
  - Reset mid-stall discards the held bundle.
  - Reset together with `flush_i` behaves as reset.
- **Simultaneous transfer out and transfer in:** the new bundle replaces the old one with no bubble.
- **Flush while stalled:** the bundle is discarded even though `ready_i` = 0.

## Structure
- `alu_op_t` already exists in `PipeTypes.svh`. Add the following there:
  - opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`;
  - a packed `id_ex_bundle_t` containing alu_op, operands, rd, rd_we, illegal and pc.
- One natural sub-module: `alu_op_decode`. It is purely combinational, mapping instr to {alu_op, operand selects, imm, illegal}. The top holds forwarding muxes, the handshake and the register.

## Test plan
- ADDI x5, x0, -1 (0xFFF00293), pc 0x100 → next cycle: valid_o = 1, ADD, A = 0, B = 0xFFFFFFFF, rd = 5, rd_we = 1.
- SUB x3, x1, x2 with rs1 = 10, rs2 = 3; EX forwards rd = 2, data 7; WB forwards rd = 2, data 9 → SUB, A = 10, B = 7 (EX priority).
- SRAI x1, x1, 4 (funct7 0100000) → SRA, B[4:0] = 4. The same encoding with funct7 0000001 → illegal_o = 1, rd_we = 0, valid_o = 1.
- AUIPC x7, 0x12345 at pc 0x80 → ADD, A = 0x80, B = 0x12345000. LUI with rd = 0 → rd_we = 0.
- Hold ready_i = 0 for 3 cycles with valid_i = 1 → ready_o = 0 and outputs stable. Release → a second bundle is accepted in the same cycle, with no bubble.
- flush_i during a stall with a new valid_i → next cycle valid_o = 0. Assert rst_i mid-stream → all outputs are 0 and ready_o = 1.

Source files
------------

// File: rtl/alu_issue_decode_pkg.sv
// Shared types for the ALU issue/decode stage: ALU operation encoding,
// RV32I opcode constants, operand selects and the ID/EX bundle.
package alu_issue_decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    A_SEL_ZERO = 2'd0,
    A_SEL_RS1  = 2'd1,
    A_SEL_PC   = 2'd2
  } a_sel_t;

  typedef enum logic [1:0] {
    B_SEL_ZERO = 2'd0,
    B_SEL_RS2  = 2'd1,
    B_SEL_IMM  = 2'd2
  } b_sel_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic [31:0] pc;
  } id_ex_bundle_t;

  // Base funct3 map shared by OP and OP-IMM (funct7 = 0000000 variants).
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    alu_op_t op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode_op_decode.sv
// Combinational RV32I integer-computational decoder: instruction to ALU
// operation, operand selects, immediate and illegal flag.
module alu_op_decode
  import alu_issue_decode_pkg::*;
(
  input  logic [31:0] instr,
  output alu_op_t     alu_op,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic        illegal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign rd       = instr[11:7];

  // Opcode/funct decode; unknown encodings fall through to the illegal default.
  always_comb begin
    alu_op  = ALU_ADD;
    a_sel   = A_SEL_ZERO;
    b_sel   = B_SEL_ZERO;
    imm     = 32'h0000_0000;
    illegal = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        a_sel = A_SEL_RS1;
        b_sel = B_SEL_RS2;
        if (funct7_s == FUNCT7_BASE) begin
          alu_op = base_op(funct3_s);
        end else if (funct7_s == FUNCT7_ALT && funct3_s == 3'b000) begin
          alu_op = ALU_SUB;
        end else if (funct7_s == FUNCT7_ALT && funct3_s == 3'b101) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        a_sel  = A_SEL_RS1;
        b_sel  = B_SEL_IMM;
        imm    = {{20{instr[31]}}, instr[31:20]};
        alu_op = base_op(funct3_s);
        // Shifts reuse the upper immediate bits as funct7.
        if (funct3_s == 3'b001) begin
          illegal = (funct7_s != FUNCT7_BASE);
        end else if (funct3_s == 3'b101) begin
          if (funct7_s == FUNCT7_ALT) begin
            alu_op = ALU_SRA;
          end else begin
            illegal = (funct7_s != FUNCT7_BASE);
          end
        end else begin
          illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        a_sel = A_SEL_ZERO;
        b_sel = B_SEL_IMM;
        imm   = {instr[31:12], 12'h000};
      end
      OPC_AUIPC: begin
        a_sel = A_SEL_PC;
        b_sel = B_SEL_IMM;
        imm   = {instr[31:12], 12'h000};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // Illegal bundles carry ADD with zero operands.
    if (illegal) begin
      alu_op = ALU_ADD;
      a_sel  = A_SEL_ZERO;
      b_sel  = B_SEL_ZERO;
      imm    = 32'h0000_0000;
    end else begin
      imm    = imm;
    end
  end

endmodule

// File: rtl/alu_issue_decode.sv
// ID/EX issue stage: decodes the instruction, resolves forwarded operands
// and registers the bundle behind a valid/ready handshake with flush.
module alu_issue_decode
  import alu_issue_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            fwd_ex_valid_i,
  input  logic [4:0]      fwd_ex_rd_i,
  input  logic [XLEN-1:0] fwd_ex_data_i,
  input  logic            fwd_wb_valid_i,
  input  logic [4:0]      fwd_wb_rd_i,
  input  logic [XLEN-1:0] fwd_wb_data_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output alu_op_t         alu_op_o,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [4:0]      rd_o,
  output logic            rd_we_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  localparam id_ex_bundle_t BUNDLE_RESET = '{
    alu_op:    ALU_ADD,
    operand_a: 32'h0000_0000,
    operand_b: 32'h0000_0000,
    rd:        5'd0,
    rd_we:     1'b0,
    illegal:   1'b0,
    pc:        32'h0000_0000
  };

  alu_op_t       dec_op_s;
  a_sel_t        dec_a_sel_s;
  b_sel_t        dec_b_sel_s;
  logic [31:0]   dec_imm_s;
  logic [4:0]    dec_rd_s;
  logic          dec_illegal_s;
  logic [31:0]   rs1_val_s;
  logic [31:0]   rs2_val_s;
  id_ex_bundle_t next_bundle_s;
  id_ex_bundle_t bundle_r;
  logic          valid_r;
  logic          xfer_in_s;

  // EX beats WB beats register file; x0 always reads zero.
  function automatic logic [31:0] resolve(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        ex_valid,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        wb_valid,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'h0000_0000;
    end else if (ex_valid && ex_rd == idx) begin
      val = ex_data;
    end else if (wb_valid && wb_rd == idx) begin
      val = wb_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  alu_op_decode u_decode (
    .instr   (instr_i),
    .alu_op  (dec_op_s),
    .a_sel   (dec_a_sel_s),
    .b_sel   (dec_b_sel_s),
    .imm     (dec_imm_s),
    .rd      (dec_rd_s),
    .illegal (dec_illegal_s)
  );

  assign rs1_val_s = resolve(instr_i[19:15], rs1_data_i, fwd_ex_valid_i, fwd_ex_rd_i,
                             fwd_ex_data_i, fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i);
  assign rs2_val_s = resolve(instr_i[24:20], rs2_data_i, fwd_ex_valid_i, fwd_ex_rd_i,
                             fwd_ex_data_i, fwd_wb_valid_i, fwd_wb_rd_i, fwd_wb_data_i);

  assign ready_o   = !valid_r || ready_i;
  assign xfer_in_s = valid_i && ready_o;

  // Assemble the incoming bundle from decode results and resolved operands.
  always_comb begin
    next_bundle_s         = BUNDLE_RESET;
    next_bundle_s.alu_op  = dec_op_s;
    next_bundle_s.rd      = dec_rd_s;
    next_bundle_s.illegal = dec_illegal_s;
    next_bundle_s.rd_we   = !dec_illegal_s && (dec_rd_s != 5'd0);
    next_bundle_s.pc      = pc_i;
    case (dec_a_sel_s)
      A_SEL_RS1: next_bundle_s.operand_a = rs1_val_s;
      A_SEL_PC:  next_bundle_s.operand_a = pc_i;
      default:   next_bundle_s.operand_a = 32'h0000_0000;
    endcase
    case (dec_b_sel_s)
      B_SEL_RS2: next_bundle_s.operand_b = rs2_val_s;
      B_SEL_IMM: next_bundle_s.operand_b = dec_imm_s;
      default:   next_bundle_s.operand_b = 32'h0000_0000;
    endcase
  end

  // ID/EX register: reset, then flush, then load, then drain; otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r  <= 1'b0;
      bundle_r <= BUNDLE_RESET;
    end else if (flush_i) begin
      valid_r  <= 1'b0;
    end else if (xfer_in_s) begin
      valid_r  <= 1'b1;
      bundle_r <= next_bundle_s;
    end else if (valid_r && ready_i) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign valid_o     = valid_r;
  assign alu_op_o    = bundle_r.alu_op;
  assign operand_a_o = bundle_r.operand_a;
  assign operand_b_o = bundle_r.operand_b;
  assign rd_o        = bundle_r.rd;
  assign rd_we_o     = bundle_r.rd_we;
  assign illegal_o   = bundle_r.illegal;
  assign pc_o        = bundle_r.pc;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed self-checking bench for alu_issue_decode with hand-computed vectors.
module tb_alu_issue_decode;
  import alu_issue_decode_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        fwd_ex_valid_i;
  logic [4:0]  fwd_ex_rd_i;
  logic [31:0] fwd_ex_data_i;
  logic        fwd_wb_valid_i;
  logic [4:0]  fwd_wb_rd_i;
  logic [31:0] fwd_wb_data_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  alu_op_t     alu_op_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;
  logic [31:0] pc_o;

  int checks = 0;
  int errors = 0;

  alu_issue_decode #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .instr_i        (instr_i),
    .pc_i           (pc_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .fwd_ex_valid_i (fwd_ex_valid_i),
    .fwd_ex_rd_i    (fwd_ex_rd_i),
    .fwd_ex_data_i  (fwd_ex_data_i),
    .fwd_wb_valid_i (fwd_wb_valid_i),
    .fwd_wb_rd_i    (fwd_wb_rd_i),
    .fwd_wb_data_i  (fwd_wb_data_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .alu_op_o       (alu_op_o),
    .operand_a_o    (operand_a_o),
    .operand_b_o    (operand_b_o),
    .rd_o           (rd_o),
    .rd_we_o        (rd_we_o),
    .illegal_o      (illegal_o),
    .pc_o           (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_bundle(input string tag, input logic v, input alu_op_t op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic we, input logic ill);
    chk({tag, ".valid"},   32'(valid_o),     32'(v));
    chk({tag, ".op"},      32'(alu_op_o),    32'(op));
    chk({tag, ".a"},       operand_a_o,      a);
    chk({tag, ".b"},       operand_b_o,      b);
    chk({tag, ".rd"},      32'(rd_o),        32'(rd));
    chk({tag, ".rd_we"},   32'(rd_we_o),     32'(we));
    chk({tag, ".illegal"}, 32'(illegal_o),   32'(ill));
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; instr_i = 32'h0; pc_i = 32'h0;
    rs1_data_i = 32'h0; rs2_data_i = 32'h0; flush_i = 1'b0; ready_i = 1'b1;
    fwd_ex_valid_i = 1'b0; fwd_ex_rd_i = 5'd0; fwd_ex_data_i = 32'h0;
    fwd_wb_valid_i = 1'b0; fwd_wb_rd_i = 5'd0; fwd_wb_data_i = 32'h0;
    step(); step();
    rst_i = 1'b0;
    chk_bundle("reset", 1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("reset.pc", pc_o, 32'h0);
    chk("reset.ready", 32'(ready_o), 32'd1);

    // ADDI x5, x0, -1; x0 must ignore a matching EX candidate on rd 0
    valid_i = 1'b1; instr_i = 32'hFFF0_0293; pc_i = 32'h100; rs1_data_i = 32'h55;
    fwd_ex_valid_i = 1'b1; fwd_ex_rd_i = 5'd0; fwd_ex_data_i = 32'hDEAD;
    step();
    chk_bundle("addi", 1'b1, ALU_ADD, 32'h0, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    chk("addi.pc", pc_o, 32'h100);

    // SUB x3, x1, x2 with EX and WB both on x2
    instr_i = 32'h4020_81B3; rs1_data_i = 32'd10; rs2_data_i = 32'd3;
    fwd_ex_valid_i = 1'b1; fwd_ex_rd_i = 5'd2; fwd_ex_data_i = 32'd7;
    fwd_wb_valid_i = 1'b1; fwd_wb_rd_i = 5'd2; fwd_wb_data_i = 32'd9;
    step();
    chk_bundle("sub", 1'b1, ALU_SUB, 32'd10, 32'd7, 5'd3, 1'b1, 1'b0);

    // ADD x4, x1, x2 with WB only on x1
    instr_i = 32'h0020_8233; fwd_ex_valid_i = 1'b0;
    fwd_wb_rd_i = 5'd1; fwd_wb_data_i = 32'd20;
    step();
    chk_bundle("add_wb", 1'b1, ALU_ADD, 32'd20, 32'd3, 5'd4, 1'b1, 1'b0);

    // SRAI x1, x1, 4
    fwd_wb_valid_i = 1'b0; instr_i = 32'h4040_D093; rs1_data_i = 32'h8000_0000;
    step();
    chk_bundle("srai", 1'b1, ALU_SRA, 32'h8000_0000, 32'h0000_0404, 5'd1, 1'b1, 1'b0);
    chk("srai.shamt", 32'(operand_b_o[4:0]), 32'd4);

    // Same encoding with funct7 0000001 is illegal
    instr_i = 32'h0240_D093;
    step();
    chk_bundle("srai_bad", 1'b1, ALU_ADD, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1);

    // AUIPC x7, 0x12345 at pc 0x80
    instr_i = 32'h1234_5397; pc_i = 32'h80;
    step();
    chk_bundle("auipc", 1'b1, ALU_ADD, 32'h80, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
    chk("auipc.pc", pc_o, 32'h80);

    // LUI x0, 0xABCDE
    instr_i = 32'hABCD_E037;
    step();
    chk_bundle("lui_x0", 1'b1, ALU_ADD, 32'h0, 32'hABCD_E000, 5'd0, 1'b0, 1'b0);

    // XORI x6, x0, 0xF loaded, then stall with ORI x8, x0, 0xAA pending
    instr_i = 32'h00F0_4313;
    step();
    chk_bundle("xori", 1'b1, ALU_XOR, 32'h0, 32'hF, 5'd6, 1'b1, 1'b0);
    instr_i = 32'h0AA0_6413; ready_i = 1'b0;
    #1;
    chk("stall.ready0", 32'(ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.ready", 32'(ready_o), 32'd0);
      chk_bundle("stall", 1'b1, ALU_XOR, 32'h0, 32'hF, 5'd6, 1'b1, 1'b0);
    end
    ready_i = 1'b1;
    #1;
    chk("release.ready", 32'(ready_o), 32'd1);
    step();
    chk_bundle("ori", 1'b1, ALU_OR, 32'h0, 32'hAA, 5'd8, 1'b1, 1'b0);

    // Flush during a stall with a new bundle offered
    ready_i = 1'b0; flush_i = 1'b1; instr_i = 32'h00F0_4313;
    step();
    chk("flush.valid", 32'(valid_o), 32'd0);
    chk("flush.ready", 32'(ready_o), 32'd1);
    flush_i = 1'b0; valid_i = 1'b0;
    step();
    chk("flush.idle", 32'(valid_o), 32'd0);

    // Drain with no new input empties the stage
    valid_i = 1'b1; ready_i = 1'b1; instr_i = 32'h1234_5397; pc_i = 32'h80;
    step();
    chk("drain.load", 32'(valid_o), 32'd1);
    valid_i = 1'b0;
    step();
    chk("drain.empty", 32'(valid_o), 32'd0);

    // Reset mid-stall discards the held bundle
    valid_i = 1'b1;
    step();
    ready_i = 1'b0; instr_i = 32'hFFF0_0293;
    step();
    chk("prerst.valid", 32'(valid_o), 32'd1);
    rst_i = 1'b1; flush_i = 1'b1;
    step();
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    chk_bundle("rst_mid", 1'b0, ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("rst_mid.pc", pc_o, 32'h0);
    chk("rst_mid.ready", 32'(ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
